// File: rtl/muldiv_if.sv
// muldiv_if: handshake and operand bundle for muldiv_unit.
//   master side (control path) drives start/kill/op/a/b;
//   slave side (muldiv_unit) drives busy/done/result.
//   start  - launch an op (sampled only while idle)
//   kill   - abort the op in flight
//   op     - funct3 code: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b   - rs1 / rs2 operands
//   busy   - op in flight
//   done   - one-cycle result-valid pulse
//   result - last completed result, held until the next done
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             kill;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, kill, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the EX-stage ALU.
//   Operates on magnitudes: signs are stripped at launch and reapplied in FIN.
//   Multiply is a WIDTH-step shift-add, divide a WIDTH-step restoring
//   shift-subtract, both sharing the {hi, lo} working register pair.
//   Divide-by-zero and signed overflow bypass the iteration entirely.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (state, busy, done, result)
//   bus  - muldiv_if.slave: start/kill/op/a/b in, busy/done/result out
// Configuration:
//   MULDIV_FAST_MUL_EN - when defined, MUL* ops use one combinational
//   WIDTHxWIDTH multiply at launch and go straight to FIN; divides unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] hi, lo, opb;
  logic             neg_q, neg_r, spec;
  logic [WIDTH-1:0] spec_res;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Launch decode: operand signs, magnitudes and the special-case bypass.
  logic             sgn_a, sgn_b, b_zero, ovf, special;
  logic [WIDTH-1:0] mag_a, mag_b, spec_val;

  always_comb begin
    // MUL's low half is sign-agnostic, so it runs unsigned.
    sgn_a   = (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV ||
               bus.op == OP_REM) && bus.a[WIDTH-1];
    sgn_b   = (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM) && bus.b[WIDTH-1];
    mag_a   = cond_neg(bus.a, sgn_a);
    mag_b   = cond_neg(bus.b, sgn_b);
    b_zero  = bus.op[2] && (bus.b == '0);
    ovf     = bus.op[2] && !bus.op[0] && (bus.a == MIN_INT) && (bus.b == '1);
    special = b_zero || ovf;
    if (b_zero) spec_val = bus.op[1] ? bus.a : '1;
    else        spec_val = bus.op[1] ? '0 : MIN_INT;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_fast;
  assign prod_fast = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  // One iteration step. Multiply: lo holds the multiplier, shifted out LSB
  // first while the partial product shifts down into it. Divide: lo holds the
  // dividend, shifted out MSB first while quotient bits shift in.
  logic [WIDTH:0]   sum, rem_t;
  logic [WIDTH-1:0] diff, hi_n, lo_n;
  logic             ge;

  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    rem_t = {hi, lo[WIDTH-1]};
    ge    = rem_t >= {1'b0, opb};
    // When ge holds the true difference is below opb, so WIDTH bits suffice.
    diff  = rem_t[WIDTH-1:0] - opb;
    if (op_r[2]) begin
      hi_n = ge ? diff : rem_t[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Finish: sign correction and half / quotient / remainder selection.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_val;

  always_comb begin
    prod = cond_neg2({hi, lo}, neg_q);
    quo  = cond_neg(lo, neg_q);
    rem  = cond_neg(hi, neg_r);
    if (spec)          fin_val = spec_res;
    else if (!op_r[2]) fin_val = (op_r[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else               fin_val = op_r[1] ? rem : quo;
  end

  // Datapath registers: no reset, qualified by the control state.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_r     <= bus.op;
      opb      <= mag_b;
      neg_q    <= sgn_a ^ sgn_b;
      neg_r    <= sgn_a;
      spec     <= special;
      spec_res <= spec_val;
`ifdef MULDIV_FAST_MUL_EN
      if (!bus.op[2]) begin
        {hi, lo} <= prod_fast;
      end else begin
        hi <= '0;
        lo <= mag_a;
      end
`else
      hi <= '0;
      lo <= mag_a;
`endif
    end else if (state == CALC) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            bus.busy <= 1'b1;
            cnt      <= '0;
`ifdef MULDIV_FAST_MUL_EN
            state    <= (special || !bus.op[2]) ? FIN : CALC;
`else
            state    <= special ? FIN : CALC;
`endif
          end
        end
        CALC: begin
          if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH-1)) state <= FIN;
          end
        end
        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (!bus.kill) begin
            bus.result <= fin_val;
            bus.done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. The driver pushes the
// reference result and the cycle its done pulse is due; a negedge monitor
// pops and compares on every done.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [31:0] MINI = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINI && b == 32'hFFFF_FFFF) return MINI;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINI && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MINI && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return W + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MINI;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, no done required", bus.result, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("result", bus.result, mon_e.res);
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("busy_in_done", 32'(bus.busy), 32'd0);
        last_res = mon_e.res;
      end
    end
  end

  // Called at a negedge; returns at a negedge with busy low (or after timeout).
  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=%b, required 0 within 100 cycles", bus.busy);
    end
  endtask

  // Launch one op. Operands are scrambled afterwards, and sometimes start is
  // held one extra cycle with junk operands, which must be ignored.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.res     = ref_model(op, a, b);
    e.cyc     = cyc + 1 + lat(op, a, b);
    sbq.push_back(e);
    @(negedge clk);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    bus.start = ($urandom_range(0, 1) == 1);
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, MINI, MINI);
    issue(3'd3, MINI, MINI);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd6, 32'd5, 32'd0);
    issue(3'd4, MINI, 32'hFFFF_FFFF);
    issue(3'd6, MINI, 32'hFFFF_FFFF);
    issue(3'd5, 32'd9, 32'd0);
    issue(3'd7, 32'd9, 32'd0);

    // kill on edge E0+10 of a DIV: no done, result holds.
    wait_idle();
    k = cyc;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", 32'(bus.busy), 32'd0);
    check("kill_result", bus.result, last_res);
    repeat (W + 4) @(negedge clk);
    issue(3'd5, 32'd1000, 32'd3);

    // kill during FIN of a divide-by-zero.
    wait_idle();
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd5; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_fin_busy", 32'(bus.busy), 32'd0);
    check("kill_fin_result", bus.result, last_res);
    repeat (4) @(negedge clk);

    // kill together with start in idle: nothing launches.
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_start_busy", 32'(bus.busy), 32'd0);
    repeat (W + 4) @(negedge clk);

    // Reset in the middle of CALC.
    issue(3'd7, 32'd12345, 32'd10);
    wait_idle();
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd77; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_result", bus.result, 32'd0);
    rst = 1'b0;
    last_res = 32'd0;
    @(negedge clk);

    // Randomized ops, back to back.
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), pick(), pick());
    end

    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still outstanding, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
